// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: processes WIDTH-bit operands DIGIT bits per cycle,
// LSB first, rippling the carry through a register between digits.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_start,
  input  logic             din_mode,
  input  logic [WIDTH-1:0] din_A,
  input  logic [WIDTH-1:0] din_B,
  input  logic             din_cin,
  output logic             dout_busy,
  output logic             dout_done,
  output logic [WIDTH-1:0] dout_sum,
  output logic             dout_carry,
  output logic             dout_overflow
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_add_sub: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   dig_sum;
  logic [WIDTH-1:0] acc_d;
  logic             cm_d;
  int               base;

  // One DIGIT-wide full-adder slice, indexed by the digit counter.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    base    = int'(cnt_q) * DIGIT;
    a_dig   = a_q[base +: DIGIT];
    b_dig   = b_q[base +: DIGIT];
    dig_sum = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    acc_d   = acc_q;
    acc_d[base +: DIGIT] = dig_sum[DIGIT-1:0];
    // Carry into the MSB, recovered from the MSB's own sum bit on the final digit.
    cm_d    = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dig_sum[DIGIT-1];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      carry_q       <= 1'b0;
      dout_busy     <= 1'b0;
      dout_done     <= 1'b0;
      dout_sum      <= '0;
      dout_carry    <= 1'b0;
      dout_overflow <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          dout_done <= 1'b0;
          if (din_start) begin
            // Subtraction is A + ~B + ~borrow; carry-out then means "no borrow".
            a_q           <= din_A;
            b_q           <= din_mode ? ~din_B : din_B;
            carry_q       <= din_mode ? ~din_cin : din_cin;
            acc_q         <= '0;
            cnt_q         <= '0;
            dout_busy     <= 1'b1;
            dout_sum      <= '0;
            dout_carry    <= 1'b0;
            dout_overflow <= 1'b0;
            state_q       <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q   <= acc_d;
          carry_q <= dig_sum[DIGIT];
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            dout_busy     <= 1'b0;
            dout_done     <= 1'b1;
            dout_sum      <= acc_d;
            dout_carry    <= dig_sum[DIGIT];
            dout_overflow <= cm_d ^ dig_sum[DIGIT];
            state_q       <= S_DONE;
          end
        end
        S_DONE: begin
          dout_done <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: an 8-bit/1-bit-digit instance and a
// 16-bit/4-bit-digit instance, checked against hand-computed results.
module tb_serial_add_sub;

  logic clk;
  logic rst;

  logic       start8, mode8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, carry8, ovf8;
  logic [7:0] sum8;

  logic        start16, mode16, cin16;
  logic [15:0] a16, b16;
  logic        busy16, done16, carry16, ovf16;
  logic [15:0] sum16;

  int n_checks = 0;
  int n_pass   = 0;

  logic        sel_wide;
  logic        obs_busy, obs_done, obs_carry, obs_ovf;
  logic [15:0] obs_sum;

  always_comb begin
    obs_busy  = sel_wide ? busy16  : busy8;
    obs_done  = sel_wide ? done16  : done8;
    obs_carry = sel_wide ? carry16 : carry8;
    obs_ovf   = sel_wide ? ovf16   : ovf8;
    obs_sum   = sel_wide ? sum16   : {8'h00, sum8};
  end

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst), .din_start(start8), .din_mode(mode8),
    .din_A(a8), .din_B(b8), .din_cin(cin8),
    .dout_busy(busy8), .dout_done(done8), .dout_sum(sum8),
    .dout_carry(carry8), .dout_overflow(ovf8)
  );

  serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .din_start(start16), .din_mode(mode16),
    .din_A(a16), .din_B(b16), .din_cin(cin16),
    .dout_busy(busy16), .dout_done(done16), .dout_sum(sum16),
    .dout_carry(carry16), .dout_overflow(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({busy8, done8, sum8, carry8, ovf8} !== 12'h000)
      $display("FAIL reset8 outputs: got %h want 000", {busy8, done8, sum8, carry8, ovf8});
    else n_pass++;
    n_checks++; if ({busy16, done16, sum16, carry16, ovf16} !== 20'h00000)
      $display("FAIL reset16 outputs: got %h want 00000", {busy16, done16, sum16, carry16, ovf16});
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One operation from IDLE through DONE and back to IDLE. Done must appear
  // N edges after the accept edge, with busy high for exactly those N cycles.
  task automatic do_op(input bit wide, input logic mode, input logic [15:0] a,
                       input logic [15:0] b, input logic cin, input logic [15:0] es,
                       input logic ec, input logic eo, input string name);
    int n_dig;
    int cyc;
    int busy_cyc;
    n_dig    = wide ? 4 : 8;
    sel_wide = wide;
    if (wide) begin
      a16 = a; b16 = b; mode16 = mode; cin16 = cin; start16 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; mode8 = mode; cin8 = cin; start8 = 1'b1;
    end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    // Operands move after the accept edge; the result must still use the latched copies.
    a8 = ~a8; b8 = ~b8; cin8 = ~cin8; mode8 = ~mode8;
    a16 = ~a16; b16 = ~b16; cin16 = ~cin16; mode16 = ~mode16;
    cyc = 0; busy_cyc = 0;
    while (obs_done !== 1'b1 && cyc < 40) begin
      if (obs_busy === 1'b1) busy_cyc++;
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++; if (obs_done !== 1'b1)
      $display("FAIL %s done_timeout: got no done within %0d cycles, want done", name, cyc);
    else n_pass++;
    n_checks++; if (cyc != n_dig)
      $display("FAIL %s latency: got %0d edges, want %0d", name, cyc, n_dig);
    else n_pass++;
    n_checks++; if (busy_cyc != n_dig)
      $display("FAIL %s busy_cycles: got %0d, want %0d", name, busy_cyc, n_dig);
    else n_pass++;
    n_checks++; if (obs_busy !== 1'b0)
      $display("FAIL %s busy_at_done: got %b, want 0", name, obs_busy);
    else n_pass++;
    n_checks++; if (obs_sum !== es)
      $display("FAIL %s sum: got %h, want %h", name, obs_sum, es);
    else n_pass++;
    n_checks++; if (obs_carry !== ec)
      $display("FAIL %s carry: got %b, want %b", name, obs_carry, ec);
    else n_pass++;
    n_checks++; if (obs_ovf !== eo)
      $display("FAIL %s overflow: got %b, want %b", name, obs_ovf, eo);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (obs_done !== 1'b0 || obs_busy !== 1'b0)
      $display("FAIL %s after_done: got done=%b busy=%b, want 0 0", name, obs_done, obs_busy);
    else n_pass++;
    n_checks++; if (obs_sum !== es)
      $display("FAIL %s sum_hold: got %h, want %h", name, obs_sum, es);
    else n_pass++;
  endtask

  task automatic test_add_sub8();
    do_op(1'b0, 1'b0, 16'h005A, 16'h0033, 1'b0, 16'h008D, 1'b0, 1'b1, "add_5A_33");
    do_op(1'b0, 1'b1, 16'h0010, 16'h0020, 1'b0, 16'h00F0, 1'b0, 1'b0, "sub_10_20");
    do_op(1'b0, 1'b0, 16'h00FF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0, "add_FF_01_c1");
    do_op(1'b0, 1'b1, 16'h0080, 16'h0001, 1'b0, 16'h007F, 1'b1, 1'b1, "sub_80_01");
    do_op(1'b0, 1'b1, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b1, 1'b0, "sub_05_03_b1");
  endtask

  task automatic test_wide16();
    do_op(1'b1, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "w16_add_FFFF_1");
    do_op(1'b1, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "w16_add_7FFF_1");
    do_op(1'b1, 1'b1, 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b0, 1'b0, "w16_sub_eq_b1");
  endtask

  // Start held for 20 edges: only one op in flight; the second is taken on the
  // IDLE edge after DONE, i.e. 10 edges after the first accept.
  task automatic test_back_to_back();
    int pulses;
    sel_wide = 1'b0;
    a8 = 8'h01; b8 = 8'h02; mode8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h10; b8 = 8'h20;
    pulses = 0;
    for (int off = 1; off < 20; off++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          n_checks++; if (off != 8 || sum8 !== 8'h03)
            $display("FAIL hold_first: got off=%0d sum=%h, want off=8 sum=03", off, sum8);
          else n_pass++;
        end else begin
          n_checks++; if (off != 18 || sum8 !== 8'h30)
            $display("FAIL hold_second: got off=%0d sum=%h, want off=18 sum=30", off, sum8);
          else n_pass++;
        end
      end
    end
    start8 = 1'b0;
    n_checks++; if (pulses != 2)
      $display("FAIL hold_pulses: got %0d, want 2", pulses);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (busy8 !== 1'b0 || done8 !== 1'b0)
      $display("FAIL hold_idle: got busy=%b done=%b, want 0 0", busy8, done8);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int seen_done;
    sel_wide = 1'b0;
    a8 = 8'h5A; b8 = 8'h33; mode8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy8 !== 1'b1)
      $display("FAIL rst_mid_busy_before: got %b, want 1", busy8);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if ({busy8, done8, sum8, carry8, ovf8} !== 12'h000)
      $display("FAIL rst_mid_out8: got %h, want 000", {busy8, done8, sum8, carry8, ovf8});
    else n_pass++;
    n_checks++; if ({busy16, done16, sum16, carry16, ovf16} !== 20'h00000)
      $display("FAIL rst_mid_out16: got %h, want 00000", {busy16, done16, sum16, carry16, ovf16});
    else n_pass++;
    seen_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) seen_done++;
    end
    n_checks++; if (seen_done != 0)
      $display("FAIL rst_mid_no_done: got %0d busy/done cycles, want 0", seen_done);
    else n_pass++;
    do_op(1'b0, 1'b0, 16'h005A, 16'h0033, 1'b0, 16'h008D, 1'b0, 1'b1, "after_rst_add");
  endtask

  initial begin
    rst = 1'b1; sel_wide = 1'b0;
    start8 = 1'b0; mode8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; mode16 = 1'b0; cin16 = 1'b0; a16 = '0; b16 = '0;
    test_reset();
    test_add_sub8();
    test_wide16();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
